// File: rtl/spi_dcs_pkg.sv
// Shared types and defaults for the dual-chip-select SPI to register-bus sequencer.
package spi_dcs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int          DEF_TIMEOUT = 64;
  localparam logic [15:0] DEF_TO_DATA = 16'hDEAD;

  // The R/W flag is the MSB of the SPI address word.
  function automatic int rw_bit(input int width_addr);
    return width_addr - 1;
  endfunction

endpackage

// File: rtl/spi_dcs_bus_ctrl_sync_edge.sv
// 2-flop synchroniser with edge detect between the two stages; edges valid 1 cycle after the pin settles.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign rise_o = meta_q & ~sync_q;
  assign fall_o = ~meta_q & sync_q;

endmodule

// File: rtl/spi_dcs_bus_ctrl.sv
// Sequences SPI transactions onto the register bus: read prefetch at address end, write commit at data end.
// bus_req rises 1 cycle after the trigger; held until ack or TIMEOUT cycles, errors kept in sticky flags.
module spi_dcs_bus_ctrl
  import spi_dcs_pkg::*;
#(
  parameter int                    width_addr = 8,
  parameter int                    width_data = 16,
  parameter int                    TIMEOUT    = DEF_TIMEOUT,
  parameter logic [width_data-1:0] TO_DATA    = width_data'(DEF_TO_DATA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_addr,
  input  logic [width_addr-1:0] Addr,
  input  logic [width_data-1:0] Dout,
  input  logic                  Data_begin,
  input  logic                  Data_end,
  output logic [width_data-1:0] Din,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [width_addr-2:0] bus_addr,
  output logic [width_data-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [width_data-1:0] bus_rdata,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_late,
  output logic                  err_overrun,
  input  logic                  err_clr
);

  localparam int         RW      = rw_bit(width_addr);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [width_addr-2:0] addr_q, addr_d;
  logic [width_data-1:0] wdata_q, wdata_d;
  logic [width_data-1:0] din_q, din_d;
  logic                  rw_q, rw_d;
  logic [width_addr-2:0] lat_q, lat_d;
  logic                  busy_q, busy_d;
  logic                  to_q, to_d, late_q, late_d, ovr_q, ovr_d;
  logic                  set_to, set_late, set_ovr;
  logic                  addr_end;

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_cs_addr),
    .rise_o  (addr_end),
    .fall_o  ()
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    din_d    = din_q;
    rw_d     = rw_q;
    lat_d    = lat_q;
    set_to   = 1'b0;
    set_late = 1'b0;
    set_ovr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (addr_end) begin
          rw_d  = Addr[RW];
          lat_d = Addr[RW-1:0];
          if (!Addr[RW]) begin
            addr_d  = Addr[RW-1:0];
            we_d    = 1'b0;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_RD;
          end
        end else if (Data_end && rw_q) begin
          addr_d  = lat_q;
          wdata_d = Dout;
          we_d    = 1'b1;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WR;
        end
      end
      ST_RD, ST_WR: begin
        set_ovr  = addr_end | (Data_end & rw_q);
        set_late = Data_begin & (state_q == ST_RD);
        // Ack wins over the timeout when both land on the last cycle.
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (state_q == ST_RD) din_d = bus_rdata;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          set_to  = 1'b1;
          state_d = ST_IDLE;
          if (state_q == ST_RD) din_d = TO_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    to_d   = (to_q   & ~err_clr) | set_to;
    late_d = (late_q & ~err_clr) | set_late;
    ovr_d  = (ovr_q  & ~err_clr) | set_ovr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      late_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      rw_q    <= rw_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      late_q  <= late_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Din         = din_q;
  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = busy_q;
  assign err_timeout = to_q;
  assign err_late    = late_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_spi_dcs_bus_ctrl.sv
// Scoreboarded bench: expected bus accesses queued at stimulus time, checked when bus_req rises and falls.
module tb_spi_dcs_bus_ctrl;

  localparam int          TO      = 64;
  localparam logic [15:0] TO_DATA = 16'hDEAD;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_at;   // req cycle carrying the ack, 0 = never
    int          len;      // expected req-high cycles, 0 = do not check
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs_addr = 1'b1;
  logic [7:0]  Addr = '0;
  logic [15:0] Dout = '0;
  logic        Data_begin = 1'b0;
  logic        Data_end = 1'b0;
  logic [15:0] Din;
  logic        bus_req, bus_we;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        busy, err_timeout, err_late, err_overrun;
  logic        err_clr = 1'b0;

  exp_t        exp_q[$];
  logic [15:0] din_model = '0;
  int          n_chk = 0;
  int          n_err = 0;

  spi_dcs_bus_ctrl #(
    .width_addr(8), .width_data(16), .TIMEOUT(TO), .TO_DATA(TO_DATA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_addr(spi_cs_addr), .Addr(Addr), .Dout(Dout),
    .Data_begin(Data_begin), .Data_end(Data_end), .Din(Din),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy),
    .err_timeout(err_timeout), .err_late(err_late), .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus-side monitor and ack responder.
  initial begin
    exp_t e;
    int   len;
    bit   seen;
    seen = 0;
    len  = 0;
    e    = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, ack_at: 0, len: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) din_model = '0;
      if (bus_req) begin
        if (!seen) begin
          seen = 1;
          len  = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
            e = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, ack_at: 0, len: 0};
          end else begin
            e = exp_q.pop_front();
            check("bus_we", 32'(bus_we), 32'(e.we));
            check("bus_addr", 32'(bus_addr), 32'(e.addr));
            check("busy_in_access", 32'(busy), 32'd1);
            if (e.we) check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
          end
        end else begin
          len++;
        end
      end else if (seen) begin
        seen = 0;
        if (e.len != 0) begin
          check("req_len", 32'(len), 32'(e.len));
          if (!e.we) din_model = (e.ack_at != 0) ? e.rdata : TO_DATA;
          check("busy_after", 32'(busy), 32'd0);
        end
        check("din", 32'(Din), 32'(din_model));
      end
      bus_ack   = bus_req && seen && (e.ack_at == len);
      bus_rdata = e.rdata;
    end
  end

  task automatic addr_phase(input logic [7:0] a);
    @(negedge clk);
    Addr        = a;
    spi_cs_addr = 1'b0;
    repeat (3) @(negedge clk);
    spi_cs_addr = 1'b1;
  endtask

  task automatic wait_req();
    int i;
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_req) break;
    end
    if (i == 12) check("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus_req) break;
    end
    if (i == 300) check("wait_done_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din", 32'(Din), 32'd0);
    check("rst_errs", {29'd0, err_timeout, err_late, err_overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read, ack on the 4th req cycle.
    exp_q.push_back('{we: 1'b0, addr: 7'h12, wdata: '0, rdata: 16'h1234, ack_at: 4, len: 4});
    addr_phase(8'h12);
    wait_done();
    check("rd_din", 32'(Din), 32'h1234);

    // Write: nothing on the bus until the data phase ends.
    exp_q.push_back('{we: 1'b1, addr: 7'h05, wdata: 16'hBEEF, rdata: 16'h7777, ack_at: 2, len: 2});
    addr_phase(8'h85);
    repeat (4) @(negedge clk);
    check("wr_no_early_req", 32'(bus_req), 32'd0);
    Data_begin = 1'b1;
    @(negedge clk);
    Data_begin = 1'b0;
    repeat (2) @(negedge clk);
    Dout     = 16'hBEEF;
    Data_end = 1'b1;
    @(negedge clk);
    Data_end = 1'b0;
    wait_done();
    check("wr_din_kept", 32'(Din), 32'h1234);

    // Read timeout.
    exp_q.push_back('{we: 1'b0, addr: 7'h40, wdata: '0, rdata: 16'h1111, ack_at: 0, len: TO});
    addr_phase(8'h40);
    wait_done();
    check("to_din", 32'(Din), 32'(TO_DATA));
    check("to_flag", 32'(err_timeout), 32'd1);
    pulse_clr();
    check("to_clr", 32'(err_timeout), 32'd0);

    // Late data phase and overrun during a read.
    exp_q.push_back('{we: 1'b0, addr: 7'h2A, wdata: '0, rdata: 16'hA5A5, ack_at: 14, len: 14});
    addr_phase(8'h2A);
    wait_req();
    @(negedge clk);
    Data_begin = 1'b1;
    @(negedge clk);
    Data_begin = 1'b0;
    check("late_flag", 32'(err_late), 32'd1);
    addr_phase(8'h33);
    repeat (3) @(negedge clk);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    wait_done();
    check("ovr_din", 32'(Din), 32'hA5A5);
    check("ovr_no_to", 32'(err_timeout), 32'd0);
    pulse_clr();
    check("clr_late", 32'(err_late), 32'd0);
    check("clr_ovr", 32'(err_overrun), 32'd0);

    // Ack on the timeout cycle.
    exp_q.push_back('{we: 1'b0, addr: 7'h7F, wdata: '0, rdata: 16'hC0DE, ack_at: TO, len: TO});
    addr_phase(8'h7F);
    wait_done();
    check("ackto_din", 32'(Din), 32'hC0DE);
    check("ackto_no_err", 32'(err_timeout), 32'd0);

    // Reset in the middle of a read.
    exp_q.push_back('{we: 1'b0, addr: 7'h11, wdata: '0, rdata: 16'h9999, ack_at: 0, len: 0});
    addr_phase(8'h11);
    wait_req();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_din", 32'(Din), 32'd0);
    check("mid_rst_bus", {8'd0, bus_we, bus_addr, bus_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    exp_q.push_back('{we: 1'b0, addr: 7'h21, wdata: '0, rdata: 16'h5A5A, ack_at: 2, len: 2});
    addr_phase(8'h21);
    wait_done();
    check("post_rst_din", 32'(Din), 32'h5A5A);
    check("final_errs", {29'd0, err_timeout, err_late, err_overrun}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/spi_dcs_bus_ctrl.md
# spi_dcs_bus_ctrl

Transaction sequencer between the dual-chip-select SPI slave interface and the on-chip SRAM-like register bus. It decodes the received address and prefetches read data before the SPI data phase begins. It commits write data once the data phase ends. It also enforces a bus timeout and reports protocol errors through sticky status flags.

## Interface
Parameters:
- width_addr, 8: SPI address width; MSB is the R/W flag (1 = write), the remaining bits are the bus address.
- width_data, 16: data width.
- TIMEOUT, 64: maximum cycles `bus_req` may wait for `bus_ack`; legal range 2..255.
- TO_DATA, 16'hDEAD: value loaded into `Din` when a read times out.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, shared with the SPI interface.
- rst_n  in  1  asynchronous active-low reset.
- spi_cs_addr  in  1  raw address chip-select pin, active low; used only to detect the end of the address phase.
- Addr  in  width_addr  address shift register from the SPI interface.
- Dout  in  width_data  received data from the SPI interface.
- Data_begin  in  1  one-cycle pulse at the start of the data phase.
- Data_end  in  1  one-cycle pulse at the end of the data phase.
- Din  out  width_data  read data for the SPI interface to transmit.
- bus_req  out  1  bus request; held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  width_addr-1  bus address.
- bus_wdata  out  width_data  write data.
- bus_ack  in  1  one-cycle acknowledge; read data valid in the same cycle.
- bus_rdata  in  width_data  read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_timeout  out  1  sticky: a bus access timed out.
- err_late  out  1  sticky: `Data_begin` arrived while a read was still pending.
- err_overrun  out  1  sticky: a new command arrived while the controller was busy.
- err_clr  in  1  synchronous clear of all sticky flags.

## Operation
- `spi_cs_addr` is synchronised through two flops. `addr_end` is the rising edge of the synchronised signal: previous stage 0, current stage 1.
- All outputs reset to 0. The FSM resets to IDLE and the timeout counter to 0.
- FSM states: IDLE, RD, WR.
- IDLE, `addr_end` with `Addr[MSB]`=0:
  - `bus_addr` <= Addr[width_addr-2:0], `bus_we` <= 0, `bus_req` <= 1; go to RD.
- IDLE, `Data_end` with the latched R/W flag = 1:
  - `bus_addr` <= latched address, `bus_wdata` <= Dout, `bus_we` <= 1, `bus_req` <= 1; go to WR.
  - The R/W flag and address are latched at every `addr_end` that is accepted in IDLE.
- `Data_end` for a read transaction is ignored. `Data_begin` never starts a bus access.
- RD / WR handshake:
  - On `bus_ack`: `bus_req` <= 0 and the state returns to IDLE. In RD, `Din` <= bus_rdata.
  - If the counter reaches TIMEOUT-1 without ack: `bus_req` <= 0, `err_timeout` <= 1, return to IDLE. In RD, `Din` <= TO_DATA.
- `Din` holds its value between reads and is never cleared except by reset.
- Error cases:
  - `addr_end` or `Data_end` (write) arriving in RD or WR is dropped and sets `err_overrun`.
  - `Data_begin` arriving in RD sets `err_late`; the interface transmits the stale `Din`.
- Simultaneous events:
  - A set condition and `err_clr` in the same cycle: the set wins.
  - `bus_ack` on the timeout cycle: the ack wins and no error is flagged.
- Reset asserted mid-access drops `bus_req` immediately. The pending access is abandoned.

## Timing
- `addr_end` in cycle N (the same cycle the interface detects it) gives `bus_req`=1 at N+1.
- Ack in cycle M gives `Din` updated and `bus_req`=0 at M+1. Back-to-back acks are impossible.
- `Data_end` in cycle N gives write `bus_req`=1 at N+1.
- Read prefetch budget: the SPI master must leave at least TIMEOUT+3 clk cycles between deasserting the address CS and asserting the data CS.
- `busy` is registered and equals (state != IDLE).
- The timeout counter is cleared on entry to RD/WR and increments each cycle without ack.

## Structure
- Shared package `spi_dcs_pkg` holds:
  - the state enum (IDLE/RD/WR);
  - the R/W bit position constant;
  - the default TIMEOUT and TO_DATA values.
- One sub-module, `sync_edge`: a 2-flop synchroniser with rising/falling edge outputs and a reset value parameter (1 for chip-selects).
- Everything else lives in a single sequential FSM block plus the counter.

## Test plan
- Read: Addr=8'h12, ack with rdata=16'h1234 after 3 cycles -> bus_addr=7'h12, bus_we=0, bus_req high for 4 cycles, Din=16'h1234, busy low afterwards.
- Write: Addr=8'h85, Data_end with Dout=16'hBEEF, ack after 1 cycle -> bus_we=1, bus_addr=7'h05, bus_wdata=16'hBEEF, no Din change.
- Timeout: read with no ack -> bus_req drops after exactly TIMEOUT cycles, Din=16'hDEAD, err_timeout=1; err_clr -> 0.
- Late/overrun: Data_begin while in RD -> err_late=1; a second addr_end while in RD -> err_overrun=1, first access completes unchanged.
- Ack coinciding with the timeout cycle -> Din=bus_rdata, err_timeout stays 0.
- Reset pulsed mid-read -> all outputs 0 immediately, state IDLE; a following read works normally.
